// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter sharing one main-memory port between icache and dcache.
// The grant is held for the whole miss transaction; the losing master is stalled and its wait cycles are counted.
//
// state  | meaning
// IDLE   | no owner, memory path driven to zero
// IC_OWN | icache owns the memory port until ic_req drops
// DC_OWN | dcache owns the memory port until dc_req drops
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ic_req,
    input  logic [ADDR_WIDTH-1:0] ic_maddr,
    input  logic                  ic_m_wen,
    input  logic [DATA_WIDTH-1:0] ic_mwrite_data,
    output logic [DATA_WIDTH-1:0] ic_mread_data,
    output logic                  ic_stall,
    input  logic                  dc_req,
    input  logic [ADDR_WIDTH-1:0] dc_maddr,
    input  logic                  dc_m_wen,
    input  logic [DATA_WIDTH-1:0] dc_mwrite_data,
    output logic [DATA_WIDTH-1:0] dc_mread_data,
    output logic                  dc_stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  ic_wait_cnt,
    output logic [CNT_WIDTH-1:0]  dc_wait_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IC_OWN = 2'd1,
        DC_OWN = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant_dc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_grant_dc <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt == IC_OWN) begin
                last_grant_dc <= 1'b0;
            end else if (state_nxt == DC_OWN) begin
                last_grant_dc <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ic_req && dc_req) begin
                    state_nxt = last_grant_dc ? IC_OWN : DC_OWN;
                end else if (ic_req) begin
                    state_nxt = IC_OWN;
                end else if (dc_req) begin
                    state_nxt = DC_OWN;
                end
            end
            IC_OWN: begin
                if (!ic_req) begin
                    state_nxt = dc_req ? DC_OWN : IDLE;
                end
            end
            DC_OWN: begin
                if (!dc_req) begin
                    state_nxt = ic_req ? IC_OWN : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ic_stall      = ic_req & (state != IC_OWN);
        dc_stall      = dc_req & (state != DC_OWN);
        mem_addr      = '0;
        mem_wen       = 1'b0;
        mem_wdata     = '0;
        ic_mread_data = '0;
        dc_mread_data = '0;
        case (state)
            IC_OWN: begin
                mem_addr      = ic_maddr;
                mem_wen       = ic_m_wen;
                mem_wdata     = ic_mwrite_data;
                ic_mread_data = mem_rdata;
            end
            DC_OWN: begin
                mem_addr      = dc_maddr;
                mem_wen       = dc_m_wen;
                mem_wdata     = dc_mwrite_data;
                dc_mread_data = mem_rdata;
            end
            default: ;
        endcase
    end

    // Saturating counters: hold at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            ic_wait_cnt <= '0;
            dc_wait_cnt <= '0;
        end else begin
            if (ic_stall && (ic_wait_cnt != '1)) begin
                ic_wait_cnt <= ic_wait_cnt + CNT_WIDTH'(1);
            end
            if (dc_stall && (dc_wait_cnt != '1)) begin
                dc_wait_cnt <= dc_wait_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a driver pushes expected outputs from a behavioural model,
// a monitor pops and compares on the falling edge. A second instance with 4-bit counters checks saturation.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ic_req, dc_req, ic_m_wen, dc_m_wen;
    logic [31:0] ic_maddr, ic_mwrite_data, dc_maddr, dc_mwrite_data, mem_rdata;
    logic [31:0] ic_mread_data, dc_mread_data, mem_addr, mem_wdata, ic_wait_cnt, dc_wait_cnt;
    logic        ic_stall, dc_stall, mem_wen;
    logic [31:0] n_ic_mread_data, n_dc_mread_data, n_mem_addr, n_mem_wdata;
    logic        n_ic_stall, n_dc_stall, n_mem_wen;
    logic [3:0]  n_ic_wait_cnt, n_dc_wait_cnt;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_maddr(ic_maddr), .ic_m_wen(ic_m_wen), .ic_mwrite_data(ic_mwrite_data),
        .ic_mread_data(ic_mread_data), .ic_stall(ic_stall),
        .dc_req(dc_req), .dc_maddr(dc_maddr), .dc_m_wen(dc_m_wen), .dc_mwrite_data(dc_mwrite_data),
        .dc_mread_data(dc_mread_data), .dc_stall(dc_stall),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ic_wait_cnt(ic_wait_cnt), .dc_wait_cnt(dc_wait_cnt)
    );

    mem_arbiter #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_maddr(ic_maddr), .ic_m_wen(ic_m_wen), .ic_mwrite_data(ic_mwrite_data),
        .ic_mread_data(n_ic_mread_data), .ic_stall(n_ic_stall),
        .dc_req(dc_req), .dc_maddr(dc_maddr), .dc_m_wen(dc_m_wen), .dc_mwrite_data(dc_mwrite_data),
        .dc_mread_data(n_dc_mread_data), .dc_stall(n_dc_stall),
        .mem_addr(n_mem_addr), .mem_wen(n_mem_wen), .mem_wdata(n_mem_wdata), .mem_rdata(mem_rdata),
        .ic_wait_cnt(n_ic_wait_cnt), .dc_wait_cnt(n_dc_wait_cnt)
    );

    typedef struct {
        bit          rst, icr, dcr, icw, dcw;
        logic [31:0] ica, icd, dca, dcd, rd;
    } stim_t;

    typedef struct {
        bit          ics, dcs, wen;
        logic [31:0] addr, wdata, icrd, dcrd, iccnt, dccnt;
        logic [3:0]  ic4, dc4;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   drive_done = 0;

    // Model: owner 0 = nobody, 1 = icache, 2 = dcache; last = most recent owner
    int      owner = 0;
    int      last  = 2;
    longint  m_ic_cnt = 0, m_dc_cnt = 0, m_ic4 = 0, m_dc4 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        int   nxt;
        @(posedge clk);
        #1;
        reset          = s.rst;
        ic_req         = s.icr;
        dc_req         = s.dcr;
        ic_m_wen       = s.icw;
        dc_m_wen       = s.dcw;
        ic_maddr       = s.ica;
        ic_mwrite_data = s.icd;
        dc_maddr       = s.dca;
        dc_mwrite_data = s.dcd;
        mem_rdata      = s.rd;

        e.ics   = s.icr && (owner != 1);
        e.dcs   = s.dcr && (owner != 2);
        e.wen   = (owner == 1) ? s.icw : (owner == 2) ? s.dcw : 1'b0;
        e.addr  = (owner == 1) ? s.ica : (owner == 2) ? s.dca : 32'h0;
        e.wdata = (owner == 1) ? s.icd : (owner == 2) ? s.dcd : 32'h0;
        e.icrd  = (owner == 1) ? s.rd : 32'h0;
        e.dcrd  = (owner == 2) ? s.rd : 32'h0;
        e.iccnt = 32'(m_ic_cnt);
        e.dccnt = 32'(m_dc_cnt);
        e.ic4   = 4'(m_ic4);
        e.dc4   = 4'(m_dc4);
        exp_q.push_back(e);

        if (s.rst) begin
            owner = 0; last = 2;
            m_ic_cnt = 0; m_dc_cnt = 0; m_ic4 = 0; m_dc4 = 0;
        end else begin
            if (e.ics) begin
                if (m_ic_cnt < 64'hFFFF_FFFF) m_ic_cnt++;
                if (m_ic4 < 15) m_ic4++;
            end
            if (e.dcs) begin
                if (m_dc_cnt < 64'hFFFF_FFFF) m_dc_cnt++;
                if (m_dc4 < 15) m_dc4++;
            end
            if (owner == 1 && s.icr)      nxt = 1;
            else if (owner == 2 && s.dcr) nxt = 2;
            else if (s.icr && s.dcr)      nxt = (last == 1) ? 2 : 1;
            else if (s.icr)               nxt = 1;
            else if (s.dcr)               nxt = 2;
            else                          nxt = 0;
            owner = nxt;
            if (nxt != 0) last = nxt;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ic_stall",      32'(ic_stall),      32'(e.ics));
                chk("dc_stall",      32'(dc_stall),      32'(e.dcs));
                chk("mem_wen",       32'(mem_wen),       32'(e.wen));
                chk("mem_addr",      mem_addr,           e.addr);
                chk("mem_wdata",     mem_wdata,          e.wdata);
                chk("ic_mread_data", ic_mread_data,      e.icrd);
                chk("dc_mread_data", dc_mread_data,      e.dcrd);
                chk("ic_wait_cnt",   ic_wait_cnt,        e.iccnt);
                chk("dc_wait_cnt",   dc_wait_cnt,        e.dccnt);
                chk("ic_wait_cnt4",  32'(n_ic_wait_cnt), 32'(e.ic4));
                chk("dc_wait_cnt4",  32'(n_dc_wait_cnt), 32'(e.dc4));
            end
        end
    end

    initial begin
        stim_t s;
        s = '{rst: 1'b1, icr: 1'b0, dcr: 1'b0, icw: 1'b0, dcw: 1'b0,
              ica: 32'h0, icd: 32'h0, dca: 32'h0, dcd: 32'h0, rd: 32'h0};
        reset = 1'b1; ic_req = 1'b0; dc_req = 1'b0; ic_m_wen = 1'b0; dc_m_wen = 1'b0;
        ic_maddr = '0; ic_mwrite_data = '0; dc_maddr = '0; dc_mwrite_data = '0; mem_rdata = '0;
        step(s); step(s);

        // Grant latency for a lone icache request
        s.rst = 1'b0;
        step(s);
        s.icr = 1'b1; s.ica = 32'h1000; s.rd = 32'hDEAD_BEEF;
        repeat (3) step(s);
        s.icr = 1'b0;
        repeat (2) step(s);

        // Tie after reset: IC first, DC waits, then a second tie goes to IC
        s.rst = 1'b1; step(s); s.rst = 1'b0;
        s.icr = 1'b1; s.dcr = 1'b1; s.dca = 32'h0000_0040; s.rd = 32'h5555_AAAA;
        repeat (9) step(s);
        s.icr = 1'b0;
        repeat (3) step(s);
        s.dcr = 1'b0;
        repeat (2) step(s);
        s.icr = 1'b1; s.dcr = 1'b1;
        repeat (4) step(s);
        s.icr = 1'b0; s.dcr = 1'b0;
        repeat (2) step(s);

        // DC write-back while IC also drives a write that must be ignored, then reset mid-transaction
        s.dcr = 1'b1; s.dcw = 1'b1; s.dca = 32'h2000; s.dcd = 32'h1234_5678;
        s.icr = 1'b1; s.icw = 1'b1; s.ica = 32'h3000; s.icd = 32'hCAFE_F00D;
        repeat (5) step(s);
        s.rst = 1'b1; step(s);
        s.rst = 1'b0;
        repeat (4) step(s);
        s.icr = 1'b0; s.dcr = 1'b0; s.icw = 1'b0; s.dcw = 1'b0;
        repeat (2) step(s);

        // IC held stalled behind DC long enough to saturate the 4-bit counter
        s.dcr = 1'b1; step(s); step(s);
        s.icr = 1'b1;
        repeat (20) step(s);
        s.icr = 1'b0; s.dcr = 1'b0;
        repeat (2) step(s);

        // Stall isolation: no IC request while DC owns
        s.rst = 1'b1; step(s); s.rst = 1'b0;
        s.dcr = 1'b1;
        for (int i = 0; i < 15; i++) begin
            s.rd = $urandom;
            step(s);
        end
        s.dcr = 1'b0;
        step(s);

        // Random traffic with sticky requests so ownerships last several cycles
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(3) == 0) s.icr = ~s.icr;
            if ($urandom_range(3) == 0) s.dcr = ~s.dcr;
            s.rst = ($urandom_range(99) == 0);
            s.icw = $urandom; s.dcw = $urandom;
            s.ica = $urandom; s.icd = $urandom;
            s.dca = $urandom; s.dcd = $urandom;
            s.rd  = $urandom;
            step(s);
        end
        drive_done = 1'b1;
    end

    initial begin
        wait (drive_done);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter between the instruction-memory cache and the data-memory cache, sharing one main-memory port. Sits directly downstream of both cache instances, consuming each cache's memory interface (address, write enable, write data) and returning read data. Grants memory to one cache at a time, holds the grant for the whole miss transaction (write-back plus line fill), and stalls the other cache through its `stall` input. Keeps saturating wait-cycle counters per master for performance analysis.

## Interface
- `ADDR_WIDTH`, 32, memory address width
- `DATA_WIDTH`, 32, memory data width
- `CNT_WIDTH`, 32, width of each wait-cycle counter
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `ic_req`  in  1  icache needs memory (driven by the top level as icache `input_ready & ~hit`)
- `ic_maddr`  in  ADDR_WIDTH  icache memory address
- `ic_m_wen`  in  1  icache memory write enable
- `ic_mwrite_data`  in  DATA_WIDTH  icache write-back data
- `ic_mread_data`  out  DATA_WIDTH  memory read data routed to the icache
- `ic_stall`  out  1  to the icache `stall` input
- `dc_req`, `dc_maddr`, `dc_m_wen`, `dc_mwrite_data`, `dc_mread_data`, `dc_stall`: same as the `ic_*` ports, for the dcache
- `mem_addr`  out  ADDR_WIDTH  main-memory address
- `mem_wen`  out  1  main-memory write enable
- `mem_wdata`  out  DATA_WIDTH  main-memory write data
- `mem_rdata`  in  DATA_WIDTH  main-memory read data, combinational for `mem_addr`
- `ic_wait_cnt`, `dc_wait_cnt`  out  CNT_WIDTH  saturating stalled-cycle counters

## Operation
- FSM states: IDLE, IC_OWN, DC_OWN. The one-bit register `last_grant` records the most recent owner (IC or DC).
- IDLE transitions:
  - If only `ic_req` is high, go to IC_OWN.
  - If only `dc_req` is high, go to DC_OWN.
  - If both are high, grant the master that is not `last_grant` (round-robin).
  - If neither is high, stay in IDLE.
- IC_OWN transitions:
  - While `ic_req` is high, stay in IC_OWN. The grant is never preempted.
  - When `ic_req` is low and `dc_req` is high, go to DC_OWN (direct handoff, no IDLE cycle).
  - When both are low, go to IDLE.
- DC_OWN transitions mirror IC_OWN.
- On entry to X_OWN, `last_grant` is set to X.
- Routing when state is X_OWN:
  - `mem_addr` = X_maddr, `mem_wdata` = X_mwrite_data, `mem_wen` = X_m_wen.
  - X_mread_data = `mem_rdata`.
  - The other master's read data is 0.
- Routing when state is IDLE:
  - `mem_wen` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - Both read-data outputs are 0.
- Stall outputs are combinational from state and request:
  - `ic_stall` = `ic_req & (state != IC_OWN)`.
  - `dc_stall` = `dc_req & (state != DC_OWN)`.
  - A master with no pending request is never stalled, so its cache hits proceed freely.
- Counters: X_wait_cnt increments by 1 on every cycle where X_stall is 1, and saturates at all-ones without wrapping.
- Memory write enable is never asserted unless the state is IC_OWN or DC_OWN. A non-owner's `m_wen` is ignored.

## Timing
- Reset values:
  - state = IDLE; `last_grant` = DC, so the first tie grants IC.
  - Both counters = 0.
  - With reset high, every output is 0 except stalls, which follow their formula (state is IDLE, so X_stall = X_req).
- Reset asserted mid-transaction forces IDLE on the next edge. The abandoned transaction is not completed.
- Grant latency: X_req rises in cycle t with state IDLE, so X_stall = 1 in cycle t. State is X_OWN in cycle t+1, where X_stall = 0 and the memory path is routed.
- Handoff: owner req falls in cycle t while the other req is high, so the other master owns and is unstalled in cycle t+1. It was stalled through cycle t.
- Simultaneous rise of both requests in IDLE: the loser stays stalled until the winner's req falls, plus one cycle.
- Owner-side routing and read data are combinational within the cycle, with no added memory latency, because caches expect same-cycle `mread_data`.
- Owner req falling and rising again in the same cycle is impossible by construction, since req is sampled once per cycle. If req drops for one cycle, the grant is released.

## Test plan
- Reset, then `ic_req`=1 at cycle 2 with `ic_maddr`=0x1000 and `mem_rdata`=0xDEADBEEF:
  - cycle 2: `ic_stall`=1, `mem_wen`=0.
  - cycle 3: `ic_stall`=0, `mem_addr`=0x1000, `ic_mread_data`=0xDEADBEEF, `dc_mread_data`=0.
- Both requests rise together after reset: IC is granted first; `dc_stall`=1 and `dc_wait_cnt` counts.
  - Drop `ic_req` after 8 cycles; DC owns the next cycle; `dc_wait_cnt`=9.
  - Repeat the tie; DC now loses, since `last_grant`=DC.
- DC owns with `dc_m_wen`=1, `dc_maddr`=0x2000, `dc_mwrite_data`=0x12345678, while IC drives `ic_m_wen`=1 and `ic_maddr`=0x3000:
  - `mem_wen`=1, `mem_addr`=0x2000, `mem_wdata`=0x12345678.
  - No write ever appears at 0x3000.
- Assert reset during a DC_OWN write-back: the next cycle is IDLE, `mem_wen`=0, both counters are 0, and the following tie grants IC.
- `CNT_WIDTH`=4 with `ic_req` held stalled 20 cycles behind a DC owner: `ic_wait_cnt` saturates at 15.
- Stall isolation: `ic_req`=0 while DC owns for many cycles, then `ic_stall`=0 every cycle and `ic_wait_cnt` stays 0.
